// File: rtl/gt_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gt_tx_pkg
// Description : Shared constants, beat type and PRBS31 helper for the
//               gt_tx_gearbox_seq TX gearbox sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gt_tx_pkg;

    localparam logic [1:0]  SYNC_DATA     = 2'b01;
    localparam logic [1:0]  SYNC_CTRL     = 2'b10;
    localparam logic [63:0] IDLE_BLOCK    = 64'h1E;
    localparam int          SEQ_PAUSE_DEF = 32;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } beat_t;

    // Advances x^31+x^28+1 by 64 bits; returns {next_state, data}, data[0] oldest.
    function automatic logic [94:0] prbs31_adv64(input logic [30:0] st);
        logic [30:0] s;
        logic [63:0] d;
        logic        nb;
        s = st;
        d = '0;
        for (int i = 0; i < 64; i++) begin
            nb   = s[30] ^ s[27];
            d[i] = nb;
            s    = {s[29:0], nb};
        end
        return {s, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gt_tx_beat_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : gt_tx_beat_fifo2
// Description : Two-entry beat FIFO with occupancy count, same-cycle push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module gt_tx_beat_fifo2 #(
    parameter int W = 66
) (
    input  logic         gt_txusrclk,
    input  logic         gt_tx_reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gt_tx_gearbox_seq.sv
`default_nettype none
// ============================================================================
// Module      : gt_tx_gearbox_seq
// Description : 64b/66b TX external-gearbox sequencer for one GTH lane.
//               Optional PRBS31 test source enabled by GT_TX_PRBS31_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gt_tx_gearbox_seq
    import gt_tx_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int SEQ_W     = 7,
    parameter int SEQ_PAUSE = SEQ_PAUSE_DEF
) (
    input  logic              gt_txusrclk,
    input  logic              gt_tx_reset,
    input  logic              tx_active,
`ifdef GT_TX_PRBS31_EN
    input  logic              prbs_en,
`endif
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        s_hdr,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] gt_txdata,
    output logic [5:0]        gt_txheader,
    output logic [SEQ_W-1:0]  gt_txsequence,
    output logic              underflow
);

    localparam logic [SEQ_W-1:0] c_seq_pause = SEQ_W'(SEQ_PAUSE);

    logic [SEQ_W-1:0]  r_seq;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_hdr;
    logic              r_underflow;

    logic [SEQ_W-1:0]  w_seq_nxt;
    logic              w_pause_nxt;
    logic              w_prbs_mode;
    logic              w_accept;
    logic              w_take;
    logic              w_bypass;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [DATA_W+1:0] w_head;

    assign w_seq_nxt   = !tx_active ? '0 :
                         (r_seq == c_seq_pause) ? '0 : r_seq + SEQ_W'(1);
    assign w_pause_nxt = (w_seq_nxt == c_seq_pause);

`ifdef GT_TX_PRBS31_EN
    logic [30:0] r_prbs;
    logic [94:0] w_prbs_adv;

    assign w_prbs_adv  = prbs31_adv64(r_prbs);
    assign w_prbs_mode = tx_active && prbs_en;

    always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            r_prbs <= '1;
        end else if (w_prbs_mode && !w_pause_nxt) begin
            r_prbs <= w_prbs_adv[94:64];
        end
    end
`else
    assign w_prbs_mode = 1'b0;
`endif

    assign s_ready  = !gt_tx_reset && tx_active && (w_count != 2'd2) && !w_prbs_mode;
    assign w_accept = s_valid && s_ready;
    assign w_take   = tx_active && !w_pause_nxt && !w_prbs_mode;
    // An empty buffer forwards the accepted beat straight to the outputs.
    assign w_bypass = w_take && w_accept && (w_count == 2'd0);
    assign w_pop    = w_take && (w_count != 2'd0);

    gt_tx_beat_fifo2 #(
        .W (DATA_W + 2)
    ) u_fifo (
        .gt_txusrclk (gt_txusrclk),
        .gt_tx_reset (gt_tx_reset),
        .push        (w_accept && !w_bypass),
        .din         ({s_hdr, s_data}),
        .pop         (w_pop),
        .dout        (w_head),
        .count       (w_count)
    );

    always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            r_seq       <= '0;
            r_data      <= IDLE_BLOCK[DATA_W-1:0];
            r_hdr       <= SYNC_CTRL;
            r_underflow <= 1'b0;
        end else begin
            r_seq       <= w_seq_nxt;
            r_underflow <= 1'b0;
            if (!tx_active) begin
                r_data <= IDLE_BLOCK[DATA_W-1:0];
                r_hdr  <= SYNC_CTRL;
            end else if (w_pause_nxt) begin
                r_data <= r_data;
                r_hdr  <= r_hdr;
`ifdef GT_TX_PRBS31_EN
            end else if (prbs_en) begin
                r_data <= w_prbs_adv[DATA_W-1:0];
                r_hdr  <= SYNC_DATA;
`endif
            end else if (w_count != 2'd0) begin
                {r_hdr, r_data} <= w_head;
            end else if (w_accept) begin
                {r_hdr, r_data} <= {s_hdr, s_data};
            end else begin
                r_data      <= IDLE_BLOCK[DATA_W-1:0];
                r_hdr       <= SYNC_CTRL;
                r_underflow <= 1'b1;
            end
        end
    end

    assign gt_txsequence = r_seq;
    assign gt_txdata     = r_data;
    assign gt_txheader   = {4'b0000, r_hdr};
    assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_gt_tx_gearbox_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gt_tx_gearbox_seq
// Description : Randomised self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gt_tx_gearbox_seq;
    import gt_tx_pkg::*;

    logic        gt_txusrclk = 1'b0;
    logic        gt_tx_reset = 1'b1;
    logic        tx_active   = 1'b1;
    logic        prbs_on     = 1'b0;
    logic [63:0] s_data      = '0;
    logic [1:0]  s_hdr       = SYNC_DATA;
    logic        s_valid     = 1'b0;
    logic        s_ready;
    logic [63:0] gt_txdata;
    logic [5:0]  gt_txheader;
    logic [6:0]  gt_txsequence;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_seq;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic        m_uf;
    beat_t       m_q[$];
    bit          m_pb[$];

    always #5 gt_txusrclk = ~gt_txusrclk;

    gt_tx_gearbox_seq dut (
        .gt_txusrclk   (gt_txusrclk),
        .gt_tx_reset   (gt_tx_reset),
        .tx_active     (tx_active),
`ifdef GT_TX_PRBS31_EN
        .prbs_en       (prbs_on),
`endif
        .s_data        (s_data),
        .s_hdr         (s_hdr),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .gt_txdata     (gt_txdata),
        .gt_txheader   (gt_txheader),
        .gt_txsequence (gt_txsequence),
        .underflow     (underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seq  = 0;
        m_data = 64'h1E;
        m_hdr  = 2'b10;
        m_uf   = 1'b0;
        m_q.delete();
        m_pb.delete();
        for (int i = 0; i < 31; i++) m_pb.push_back(1'b1);
    endtask

    // PRBS31 as the recurrence b[n] = b[n-31] ^ b[n-28] over the last 31 bits.
    function automatic logic [63:0] prbs_next64();
        logic [63:0] r;
        bit          b;
        for (int i = 0; i < 64; i++) begin
            b = m_pb[0] ^ m_pb[3];
            m_pb.push_back(b);
            void'(m_pb.pop_front());
            r[i] = b;
        end
        return r;
    endfunction

    function automatic bit exp_ready();
        return tx_active && (m_q.size() < 2) && !prbs_on;
    endfunction

    task automatic model_edge();
        int nseq;
        nseq = !tx_active ? 0 : ((m_seq == 32) ? 0 : m_seq + 1);
        if (s_valid && exp_ready()) m_q.push_back('{hdr: s_hdr, data: s_data});
        m_uf = 1'b0;
        if (!tx_active) begin
            m_data = 64'h1E;
            m_hdr  = 2'b10;
        end else if (nseq == 32) begin
            // GT ignores this beat: outputs held
        end else if (prbs_on) begin
            m_data = prbs_next64();
            m_hdr  = 2'b01;
        end else if (m_q.size() > 0) begin
            m_hdr  = m_q[0].hdr;
            m_data = m_q[0].data;
            void'(m_q.pop_front());
        end else begin
            m_data = 64'h1E;
            m_hdr  = 2'b10;
            m_uf   = 1'b1;
        end
        m_seq = nseq;
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic act);
        s_valid   = v;
        s_data    = d;
        s_hdr     = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        tx_active = act;
        @(posedge gt_txusrclk);
        model_edge();
        @(negedge gt_txusrclk);
        chk("seq",       64'(gt_txsequence), 64'(m_seq));
        chk("txdata",    gt_txdata,          m_data);
        chk("txheader",  64'(gt_txheader),   {58'd0, 4'd0, m_hdr});
        chk("underflow", 64'(underflow),     64'(m_uf));
        chk("s_ready",   64'(s_ready),       64'(exp_ready()));
    endtask

    task automatic apply_reset();
        gt_tx_reset = 1'b1;
        #1;
        model_reset();
        chk("rst_seq",   64'(gt_txsequence), 64'd0);
        chk("rst_data",  gt_txdata,          64'h1E);
        chk("rst_hdr",   64'(gt_txheader),   64'h2);
        chk("rst_uf",    64'(underflow),     64'd0);
        chk("rst_ready", 64'(s_ready),       64'd0);
        repeat (2) @(negedge gt_txusrclk);
        gt_tx_reset = 1'b0;
    endtask

    logic [63:0] cnt;

    initial begin
        model_reset();
        @(negedge gt_txusrclk);
        apply_reset();

        // Idle stream after reset
        for (int i = 0; i < 40; i++) step(1'b0, 64'd0, 1'b1);

        // Continuous incrementing stream across pause slots
        cnt = 64'd1;
        for (int i = 0; i < 70; i++) begin
            step(1'b1, cnt, 1'b1);
            if (m_q.size() > 0 || s_valid) cnt = (m_q.size() > 0 && m_q[m_q.size()-1].data == cnt) || m_data == cnt ? cnt + 1 : cnt;
        end

        // tx_active drop at seq 17 with beats buffered, then drain
        for (int i = 0; i < 100 && m_seq != 17; i++) step(1'b1, cnt++, 1'b1);
        chk("reach_seq17", 64'(m_seq), 64'd17);
        for (int i = 0; i < 5; i++) step(1'b1, 64'hDEAD, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 64'd0, 1'b1);

        // Reset with two beats buffered
        for (int i = 0; i < 200 && m_q.size() != 2; i++) step(1'b1, {32'hB00F, 32'(i)}, 1'b1);
        chk("fill2", 64'(m_q.size()), 64'd2);
        apply_reset();
        for (int i = 0; i < 40; i++) step(1'b0, 64'd0, 1'b1);

        // Push and pop together with one beat held
        for (int i = 0; i < 100 && m_q.size() != 1; i++) step(1'b1, 64'h100 + 64'(i), 1'b1);
        chk("fill1", 64'(m_q.size()), 64'd1);
        step(1'b1, 64'hAA, 1'b1);
        step(1'b1, 64'hBB, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1);

        // Random traffic with occasional tx_active drops
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
                 1'($urandom_range(0, 15) != 0));

`ifdef GT_TX_PRBS31_EN
        prbs_on = 1'b1;
        for (int n = 0; n < 2048; ) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
            if (m_seq != 32) n++;
        end
        prbs_on = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 64'h55, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
